// File: rtl/cpri_rx_pack_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpri_rx_pack_if : receive loop-buffer write port (write strobe/address/data,
//                   slot commit, free-slot count back from the buffer)
// Rev 1.0
// ----------------------------------------------------------------------------
interface cpri_rx_pack_if;
  logic        cpri_wen;
  logic [6:0]  cpri_waddr;
  logic [63:0] cpri_wdata;
  logic        cpri_wlast;
  logic [3:0]  free_size;

  modport master (
    output cpri_wen, cpri_waddr, cpri_wdata, cpri_wlast,
    input  free_size
  );

  modport slave (
    input  cpri_wen, cpri_waddr, cpri_wdata, cpri_wlast,
    output free_size
  );
endinterface
`default_nettype wire

// File: rtl/cpri_rx_pack.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpri_rx_pack : packs the CPRI IQ stream into loop-buffer slots (payload at 3..,
//                header at 0..2, commit on wlast). Option macro: CPRI_RX_CHKSUM_EN
// Rev 1.0
// ----------------------------------------------------------------------------
module cpri_rx_pack #(
  parameter int          PAYLOAD_WORDS = 96,
  parameter int          FIFO_DEPTH    = 8,
  parameter logic [15:0] MAGIC         = 16'hC5A5
) (
  input  wire            clk,
  input  wire            rst_n,
  input  wire            i_iq_rx_valid,
  input  wire  [63:0]    i_iq_rx_data,
  input  wire            i_rx_resync,
  cpri_rx_pack_if.master bus,
  output logic           o_ovf,
  output logic [15:0]    o_drop_cnt
);

  localparam int              c_aw        = $clog2(FIFO_DEPTH);
  localparam int              c_cw        = $clog2(PAYLOAD_WORDS);
  localparam logic [c_cw-1:0] c_icnt_last = c_cw'(PAYLOAD_WORDS - 1);
  localparam logic [c_aw:0]   c_depth     = (c_aw+1)'(FIFO_DEPTH);

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_pld  = 3'd1;
  localparam logic [2:0] c_st_hdr0 = 3'd2;
  localparam logic [2:0] c_st_hdr1 = 3'd3;
  localparam logic [2:0] c_st_hdr2 = 3'd4;

  logic [2:0]      r_state, w_next_state;
  logic [c_cw-1:0] r_icnt;
  logic [31:0]     r_cyc, r_in_ts, r_hdr_ts;
  logic            r_in_drop, r_in_flag, r_hdr_flag;
  logic [15:0]     r_seq, r_drop_cnt;
  logic            r_ovf;
  logic            r_wen, r_wlast, w_wen, w_wlast;
  logic [6:0]      r_waddr, w_waddr;
  logic [63:0]     r_wdata, w_wdata, w_chk;

  logic [63:0]     r_fifo_data [FIFO_DEPTH];
  logic [6:0]      r_fifo_addr [FIFO_DEPTH];
  logic            r_fifo_last [FIFO_DEPTH];
  logic [c_aw:0]   r_wr_ptr, r_rd_ptr;
  logic [c_aw-1:0] w_wr_idx, w_rd_idx, w_tail_idx;
  logic            w_empty, w_full, w_first, w_is_last, w_drop_cur;
  logic            w_push_req, w_push, w_discard, w_pop, w_flag_cur;

  assign w_wr_idx   = r_wr_ptr[c_aw-1:0];
  assign w_rd_idx   = r_rd_ptr[c_aw-1:0];
  assign w_tail_idx = w_wr_idx - c_aw'(1);
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = ((r_wr_ptr - r_rd_ptr) == c_depth);
  assign w_first    = (r_icnt == '0);
  assign w_is_last  = (r_icnt == c_icnt_last);
  // Slot availability is decided once, on the first word, and held for the packet
  assign w_drop_cur = w_first ? (bus.free_size == 4'd0) : r_in_drop;
  assign w_pop      = !w_empty && !i_rx_resync && (r_state == c_st_idle || r_state == c_st_pld);
  assign w_push_req = i_iq_rx_valid && !i_rx_resync && !w_drop_cur;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_discard  = w_push_req && w_full && !w_pop;
  assign w_flag_cur = (w_first ? 1'b0 : r_in_flag) | w_discard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cyc <= '0;
    else        r_cyc <= r_cyc + 32'd1;
  end

  // Header metadata is copied on the last input word so the next packet can start early
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_icnt     <= '0;
      r_in_drop  <= 1'b0;
      r_in_flag  <= 1'b0;
      r_in_ts    <= '0;
      r_hdr_flag <= 1'b0;
      r_hdr_ts   <= '0;
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (i_rx_resync) begin
      r_icnt    <= '0;
      r_in_drop <= 1'b0;
      r_in_flag <= 1'b0;
    end else if (i_iq_rx_valid) begin
      r_icnt    <= w_is_last ? '0 : r_icnt + c_cw'(1);
      r_in_drop <= w_drop_cur;
      if (w_first && w_drop_cur)  r_drop_cnt <= r_drop_cnt + 16'd1;
      if (w_first && !w_drop_cur) r_in_ts    <= r_cyc;
      if (!w_drop_cur)            r_in_flag  <= w_flag_cur;
      if (w_discard)              r_ovf      <= 1'b1;
      if (w_is_last && !w_drop_cur) begin
        r_hdr_flag <= w_flag_cur;
        r_hdr_ts   <= w_first ? r_cyc : r_in_ts;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_rx_resync) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (c_aw+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (c_aw+1)'(1);
    end
  end

  // A discarded last word moves its last tag onto the newest queued entry
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[w_wr_idx] <= i_iq_rx_data;
      r_fifo_addr[w_wr_idx] <= 7'(r_icnt) + 7'd3;
      r_fifo_last[w_wr_idx] <= w_is_last;
    end
    if (w_discard && w_is_last) r_fifo_last[w_tail_idx] <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle, c_st_pld:
        if (w_pop) w_next_state = r_fifo_last[w_rd_idx] ? c_st_hdr0 : c_st_pld;
      c_st_hdr0: w_next_state = c_st_hdr1;
      c_st_hdr1: w_next_state = c_st_hdr2;
      c_st_hdr2: w_next_state = w_empty ? c_st_idle : c_st_pld;
      default:   w_next_state = c_st_idle;
    endcase
    if (i_rx_resync) w_next_state = c_st_idle;
  end

  always_comb begin
    w_wen   = 1'b0;
    w_waddr = 7'd0;
    w_wdata = 64'd0;
    w_wlast = 1'b0;
    case (r_state)
      c_st_idle, c_st_pld: begin
        w_wen   = w_pop;
        w_waddr = w_pop ? r_fifo_addr[w_rd_idx] : 7'd0;
        w_wdata = w_pop ? r_fifo_data[w_rd_idx] : 64'd0;
      end
      c_st_hdr0: begin
        w_wen   = 1'b1;
        w_waddr = 7'd0;
        w_wdata = {MAGIC, r_seq, 8'd0, 8'(PAYLOAD_WORDS), 8'd0, 7'd0, r_hdr_flag};
      end
      c_st_hdr1: begin
        w_wen   = 1'b1;
        w_waddr = 7'd1;
        w_wdata = {32'd0, r_hdr_ts};
      end
      c_st_hdr2: begin
        w_wen   = 1'b1;
        w_waddr = 7'd2;
        w_wdata = w_chk;
        w_wlast = 1'b1;
      end
      default: ;
    endcase
    if (i_rx_resync) begin
      w_wen   = 1'b0;
      w_wlast = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_wlast <= 1'b0;
      r_seq   <= '0;
    end else begin
      r_wen   <= w_wen;
      r_waddr <= w_waddr;
      r_wdata <= w_wdata;
      r_wlast <= w_wlast;
      if (r_state == c_st_hdr2 && !i_rx_resync) r_seq <= r_seq + 16'd1;
    end
  end

`ifdef CPRI_RX_CHKSUM_EN
  logic [63:0] r_chk;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    r_chk <= '0;
    else if (i_rx_resync || r_state == c_st_hdr2)  r_chk <= '0;
    else if (w_pop)                                r_chk <= r_chk ^ r_fifo_data[w_rd_idx];
  end
  assign w_chk = r_chk;
`else
  assign w_chk = 64'd0;
`endif

  assign bus.cpri_wen   = r_wen;
  assign bus.cpri_waddr = r_waddr;
  assign bus.cpri_wdata = r_wdata;
  assign bus.cpri_wlast = r_wlast;
  assign o_ovf          = r_ovf;
  assign o_drop_cnt     = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cpri_rx_pack.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cpri_rx_pack : directed bench for cpri_rx_pack (FIFO_DEPTH=4)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_cpri_rx_pack;

  typedef struct {
    logic [6:0]  addr;
    logic [63:0] data;
    logic        lst;
    int unsigned cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        iq_valid = 1'b0;
  logic [63:0] iq_data = '0;
  logic        resync = 1'b0;
  logic        ovf;
  logic [15:0] drop_cnt;

  int          n_total = 0;
  int          n_bad = 0;
  int unsigned tb_cyc;
  int          wlast_cnt = 0;
  wr_t         wq[$];
  wr_t         eq[$];
  logic [63:0] pd [96];

  cpri_rx_pack_if bus();

  cpri_rx_pack #(
    .PAYLOAD_WORDS (96),
    .FIFO_DEPTH    (4),
    .MAGIC         (16'hC5A5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_iq_rx_valid (iq_valid),
    .i_iq_rx_data  (iq_data),
    .i_rx_resync   (resync),
    .bus           (bus.master),
    .o_ovf         (ovf),
    .o_drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= 0;
    else        tb_cyc <= tb_cyc + 1;
  end

  always @(negedge clk) begin
    if (rst_n && bus.cpri_wen) begin
      wr_t w;
      w.addr = bus.cpri_waddr;
      w.data = bus.cpri_wdata;
      w.lst  = bus.cpri_wlast;
      w.cyc  = tb_cyc;
      wq.push_back(w);
      if (bus.cpri_wlast) wlast_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    iq_valid = 1'b0;
    resync = 1'b0;
    bus.free_size = 4'd4;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic fill(input int p);
    for (int i = 0; i < 96; i++)
      pd[i] = {16'hD000 + 16'(p), 16'(i * 7), 32'(i * i + p)};
  endtask

  task automatic send_pkt(input int gap, input logic [3:0] fs0, input logic [3:0] fs_rest,
                          output int unsigned ts);
    ts = 0;
    for (int i = 0; i < 96; i++) begin
      iq_valid = 1'b1;
      iq_data = pd[i];
      bus.free_size = (i == 0) ? fs0 : fs_rest;
      if (i == 0) ts = tb_cyc;
      @(negedge clk);
      if (gap != 0 && (i + 1) % gap == 0) begin
        iq_valid = 1'b0;
        @(negedge clk);
      end
    end
    iq_valid = 1'b0;
    bus.free_size = 4'd4;
  endtask

  // expected writes for one packet; words skip_lo..skip_hi never reach the buffer
  task automatic exp_pkt(input logic [15:0] seq, input logic [7:0] flags, input int unsigned ts,
                         input int skip_lo, input int skip_hi);
    wr_t w;
    logic [63:0] x;
    x = '0;
    w.cyc = 0;
    w.lst = 1'b0;
    for (int i = 0; i < 96; i++) begin
      if (i < skip_lo || i > skip_hi) begin
        w.addr = 7'(i + 3);
        w.data = pd[i];
        eq.push_back(w);
        x = x ^ pd[i];
      end
    end
`ifndef CPRI_RX_CHKSUM_EN
    x = '0;
`endif
    w.addr = 7'd0; w.data = {16'hC5A5, seq, 8'd0, 8'd96, 8'd0, flags}; eq.push_back(w);
    w.addr = 7'd1; w.data = {32'd0, ts};                              eq.push_back(w);
    w.addr = 7'd2; w.data = x; w.lst = 1'b1;                          eq.push_back(w);
  endtask

  task automatic wait_wlast(input string tag, input int n, input int lb);
    for (int k = 0; k < 1500 && (wlast_cnt - lb) < n; k++) @(negedge clk);
    repeat (8) @(negedge clk);
    chk({tag, ".wlast_cnt"}, 64'(wlast_cnt - lb), 64'(n));
  endtask

  task automatic cmp_stream(input string tag, input int wb);
    chk({tag, ".len"}, 64'(wq.size() - wb), 64'(eq.size()));
    for (int i = 0; i < eq.size(); i++) begin
      if (wb + i < wq.size()) begin
        chk($sformatf("%s.w%0d.addr", tag, i), 64'(wq[wb+i].addr), 64'(eq[i].addr));
        chk($sformatf("%s.w%0d.data", tag, i), wq[wb+i].data, eq[i].data);
        chk($sformatf("%s.w%0d.last", tag, i), 64'(wq[wb+i].lst), 64'(eq[i].lst));
      end
    end
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, ".wen"},   64'(bus.cpri_wen),   64'd0);
    chk({tag, ".waddr"}, 64'(bus.cpri_waddr), 64'd0);
    chk({tag, ".wdata"}, bus.cpri_wdata,      64'd0);
    chk({tag, ".wlast"}, 64'(bus.cpri_wlast), 64'd0);
    chk({tag, ".ovf"},   64'(ovf),            64'd0);
    chk({tag, ".drop"},  64'(drop_cnt),       64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned ts1, ts2, ts3, dummy;
    int wb, lb;
    logic found;

    do_reset();
    chk_outs_zero("reset");

    // single packet, data = index
    do_reset();
    for (int i = 0; i < 96; i++) pd[i] = 64'(i);
    wb = wq.size(); lb = wlast_cnt; eq.delete();
    send_pkt(0, 4'd4, 4'd4, ts1);
    exp_pkt(16'd0, 8'd0, ts1, 999, 999);
    wait_wlast("single", 1, lb);
    cmp_stream("single", wb);
    if (wq.size() >= wb + 99) begin
      chk("single.latency",  64'(wq[wb].cyc - ts1),         64'd2);
      chk("single.hdr0_gap", 64'(wq[wb+96].cyc - wq[wb+95].cyc), 64'd1);
      chk("single.wlast_gap", 64'(wq[wb+98].cyc - wq[wb+95].cyc), 64'd3);
    end
    chk("single.ovf", 64'(ovf), 64'd0);

    // back-to-back with a control-word gap every 32 words
    do_reset();
    wb = wq.size(); lb = wlast_cnt; eq.delete();
    fill(1); send_pkt(32, 4'd4, 4'd4, ts1); exp_pkt(16'd0, 8'd0, ts1, 999, 999);
    fill(2); send_pkt(32, 4'd4, 4'd4, ts2); exp_pkt(16'd1, 8'd0, ts2, 999, 999);
    wait_wlast("b2b", 2, lb);
    cmp_stream("b2b", wb);
    chk("b2b.ovf", 64'(ovf), 64'd0);

    // three continuous packets: the third loses words 4..6 during the second header
    do_reset();
    wb = wq.size(); lb = wlast_cnt; eq.delete();
    fill(3); send_pkt(0, 4'd4, 4'd4, ts1); exp_pkt(16'd0, 8'd0, ts1, 999, 999);
    fill(4); send_pkt(0, 4'd4, 4'd4, ts2); exp_pkt(16'd1, 8'd0, ts2, 999, 999);
    fill(5); send_pkt(0, 4'd4, 4'd4, ts3); exp_pkt(16'd2, 8'd1, ts3, 4, 6);
    wait_wlast("ovf", 3, lb);
    cmp_stream("ovf", wb);
    chk("ovf.flag", 64'(ovf), 64'd1);

    // resync after 50 words, then a fresh packet
    do_reset();
    lb = wlast_cnt;
    fill(11);
    for (int i = 0; i < 50; i++) begin
      iq_valid = 1'b1;
      iq_data = pd[i];
      @(negedge clk);
    end
    resync = 1'b1;
    iq_data = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk);
    resync = 1'b0;
    iq_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("resync.no_commit", 64'(wlast_cnt - lb), 64'd0);
    wb = wq.size(); lb = wlast_cnt; eq.delete();
    fill(12); send_pkt(0, 4'd4, 4'd4, ts1); exp_pkt(16'd0, 8'd0, ts1, 999, 999);
    wait_wlast("resync", 1, lb);
    cmp_stream("resync", wb);

    // no free slot at packet 2 (free_size only matters on a first word)
    do_reset();
    wb = wq.size(); lb = wlast_cnt; eq.delete();
    fill(6); send_pkt(32, 4'd4, 4'd0, ts1); exp_pkt(16'd0, 8'd0, ts1, 999, 999);
    fill(7); send_pkt(32, 4'd0, 4'd4, dummy);
    fill(8); send_pkt(32, 4'd4, 4'd4, ts3); exp_pkt(16'd1, 8'd0, ts3, 999, 999);
    wait_wlast("drop", 2, lb);
    cmp_stream("drop", wb);
    chk("drop.cnt", 64'(drop_cnt), 64'd1);

    // asynchronous reset while the FSM sits in HDR1
    fill(9); send_pkt(0, 4'd4, 4'd4, dummy);
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clk);
      if (bus.cpri_wen && bus.cpri_waddr == 7'd0) found = 1'b1;
    end
    chk("areset.hdr_seen", 64'(found), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_outs_zero("areset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    wb = wq.size(); lb = wlast_cnt; eq.delete();
    fill(10); send_pkt(0, 4'd4, 4'd4, ts1); exp_pkt(16'd0, 8'd0, ts1, 999, 999);
    wait_wlast("areset", 1, lb);
    cmp_stream("areset", wb);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
